// File: rtl/cu_rv32i.sv
// cu_rv32i: pipelined RV32I control unit. Decodes opcode/funct3/funct7b5 in D
// and carries the control bundle through the E, M and W pipeline registers.
// Ports:
//   clock, reset                      clock, synchronous active-high reset
//   opD, funct3D, funct7b5D           instruction fields in the D stage
//   ImmSrcD, IllegalD                 combinational D-stage decode outputs
//   StallE, FlushE, FlushM            hazard-unit controls
//   ZeroE, LtE, LtuE                  ALU compare flags for the E stage
//   PCSrcE, PCTgtSrcE, ALUControlE,
//   ALUSrcAE, ALUSrcBE, ResultSrcEb0  E-stage controls
//   MemWriteM, MemSizeM, RegWriteM    M-stage controls
//   RegWriteW, ResultSrcW             W-stage controls
module cu_rv32i #(
    parameter int ALUC_W      = 4,
    parameter bit BRANCH_FULL = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [6:0]        opD,
    input  logic [2:0]        funct3D,
    input  logic              funct7b5D,
    output logic [2:0]        ImmSrcD,
    output logic              IllegalD,
    input  logic              StallE,
    input  logic              FlushE,
    input  logic              FlushM,
    input  logic              ZeroE,
    input  logic              LtE,
    input  logic              LtuE,
    output logic              PCSrcE,
    output logic              PCTgtSrcE,
    output logic [ALUC_W-1:0] ALUControlE,
    output logic              ALUSrcAE,
    output logic              ALUSrcBE,
    output logic              ResultSrcEb0,
    output logic              MemWriteM,
    output logic [2:0]        MemSizeM,
    output logic              RegWriteM,
    output logic              RegWriteW,
    output logic [1:0]        ResultSrcW
);

    typedef struct packed {
        logic       rw;
        logic [1:0] rs;
        logic       mw;
        logic       jmp;
        logic       br;
        logic [2:0] f3;
        logic [3:0] alu;
        logic       sa;
        logic       sb;
        logic       jalr;
    } e_t;

    typedef struct packed {
        logic       rw;
        logic [1:0] rs;
        logic       mw;
        logic [2:0] f3;
    } m_t;

    typedef struct packed {
        logic       rw;
        logic [1:0] rs;
    } w_t;

    e_t e_d, e_q;
    m_t m_d, m_q;
    w_t w_d, w_q;

    // alt selects sub (funct3 000) or sra (funct3 101)
    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
        logic [3:0] r;
        case (f3)
            3'b000:  r = alt ? 4'h1 : 4'h0;
            3'b001:  r = 4'h7;
            3'b010:  r = 4'h5;
            3'b011:  r = 4'h6;
            3'b100:  r = 4'h4;
            3'b101:  r = alt ? 4'h9 : 4'h8;
            3'b110:  r = 4'h3;
            default: r = 4'h2;
        endcase
        return r;
    endfunction

    logic       rw, mw, jmp, br, sa, sb, jalr, ill;
    logic [1:0] rs;
    logic [3:0] alu;
    logic [2:0] imm;

    always_comb begin
        rw   = 1'b0;
        rs   = 2'b00;
        mw   = 1'b0;
        jmp  = 1'b0;
        br   = 1'b0;
        alu  = 4'h0;
        sa   = 1'b0;
        sb   = 1'b0;
        jalr = 1'b0;
        imm  = 3'b000;
        ill  = 1'b0;
        case (opD)
            7'b0110011: begin
                rw  = 1'b1;
                alu = alu_op(funct3D, funct7b5D);
            end
            7'b0010011: begin
                rw  = 1'b1;
                sb  = 1'b1;
                // addi has no subtract form; funct7b5 only picks srai
                alu = alu_op(funct3D, funct7b5D & (funct3D != 3'b000));
            end
            7'b0000011: begin
                rw = 1'b1;
                rs = 2'b01;
                sb = 1'b1;
            end
            7'b0100011: begin
                mw  = 1'b1;
                sb  = 1'b1;
                imm = 3'b001;
            end
            7'b1100011: begin
                br  = 1'b1;
                alu = 4'h1;
                imm = 3'b010;
                if (BRANCH_FULL)
                    ill = (funct3D[2:1] == 2'b01);
                else
                    ill = (funct3D[2:1] != 2'b00);
            end
            7'b1101111: begin
                rw  = 1'b1;
                jmp = 1'b1;
                rs  = 2'b10;
                imm = 3'b011;
            end
            7'b1100111: begin
                rw   = 1'b1;
                jmp  = 1'b1;
                jalr = 1'b1;
                rs   = 2'b10;
                sb   = 1'b1;
            end
            7'b0110111: begin
                rw  = 1'b1;
                sb  = 1'b1;
                alu = 4'hA;
                imm = 3'b100;
            end
            7'b0010111: begin
                rw  = 1'b1;
                sa  = 1'b1;
                sb  = 1'b1;
                imm = 3'b100;
            end
            7'b0000000: ;
            default: ill = 1'b1;
        endcase
    end

    assign ImmSrcD  = imm;
    assign IllegalD = ill;

    // Illegal instructions enter E with every side effect suppressed
    always_comb begin
        e_d      = '0;
        e_d.rw   = rw & ~ill;
        e_d.rs   = rs;
        e_d.mw   = mw & ~ill;
        e_d.jmp  = jmp & ~ill;
        e_d.br   = br & ~ill;
        e_d.f3   = funct3D;
        e_d.alu  = alu;
        e_d.sa   = sa;
        e_d.sb   = sb;
        e_d.jalr = jalr;
    end

    always_comb begin
        m_d    = '0;
        m_d.rw = e_q.rw;
        m_d.rs = e_q.rs;
        m_d.mw = e_q.mw;
        m_d.f3 = e_q.f3;
        w_d    = '0;
        w_d.rw = m_q.rw;
        w_d.rs = m_q.rs;
    end

    // A stalled E instruction must not also advance, so M takes a bubble
    always_ff @(posedge clock) begin
        if (reset || FlushE)
            e_q <= '0;
        else if (!StallE)
            e_q <= e_d;

        if (reset || FlushM || StallE)
            m_q <= '0;
        else
            m_q <= m_d;

        if (reset)
            w_q <= '0;
        else
            w_q <= w_d;
    end

    logic cond;

    always_comb begin
        cond = 1'b0;
        case (e_q.f3)
            3'b000:  cond = ZeroE;
            3'b001:  cond = ~ZeroE;
            3'b100:  cond = LtE;
            3'b101:  cond = ~LtE;
            3'b110:  cond = LtuE;
            3'b111:  cond = ~LtuE;
            default: cond = 1'b0;
        endcase
    end

    assign PCSrcE       = e_q.jmp | (e_q.br & cond);
    assign PCTgtSrcE    = e_q.jalr;
    assign ALUControlE  = ALUC_W'(e_q.alu);
    assign ALUSrcAE     = e_q.sa;
    assign ALUSrcBE     = e_q.sb;
    assign ResultSrcEb0 = e_q.rs[0];
    assign MemWriteM    = m_q.mw;
    assign MemSizeM     = m_q.f3;
    assign RegWriteM    = m_q.rw;
    assign RegWriteW    = w_q.rw;
    assign ResultSrcW   = w_q.rs;

endmodule

// File: tb/tb_cu_rv32i.sv
// tb_cu_rv32i: directed and randomized checks of cu_rv32i against an
// instruction-level reference model with operand-based branch evaluation.
module tb_cu_rv32i;

    localparam bit [6:0] OP_R     = 7'h33;
    localparam bit [6:0] OP_I     = 7'h13;
    localparam bit [6:0] OP_LD    = 7'h03;
    localparam bit [6:0] OP_ST    = 7'h23;
    localparam bit [6:0] OP_BR    = 7'h63;
    localparam bit [6:0] OP_JAL   = 7'h6F;
    localparam bit [6:0] OP_JALR  = 7'h67;
    localparam bit [6:0] OP_LUI   = 7'h37;
    localparam bit [6:0] OP_AUIPC = 7'h17;

    localparam bit [3:0] A_ADD = 4'h0, A_SUB = 4'h1, A_AND = 4'h2;
    localparam bit [3:0] A_OR = 4'h3, A_XOR = 4'h4, A_SLT = 4'h5;
    localparam bit [3:0] A_SLTU = 4'h6, A_SLL = 4'h7, A_SRL = 4'h8;
    localparam bit [3:0] A_SRA = 4'h9, A_PASSB = 4'hA;

    logic       clock = 1'b0;
    logic       reset;
    logic [6:0] opD;
    logic [2:0] funct3D;
    logic       funct7b5D;
    logic [2:0] ImmSrcD;
    logic       IllegalD;
    logic       StallE, FlushE, FlushM;
    logic       ZeroE, LtE, LtuE;
    logic       PCSrcE, PCTgtSrcE;
    logic [3:0] ALUControlE;
    logic       ALUSrcAE, ALUSrcBE, ResultSrcEb0;
    logic       MemWriteM;
    logic [2:0] MemSizeM;
    logic       RegWriteM, RegWriteW;
    logic [1:0] ResultSrcW;

    logic [31:0] a, b;

    always #5 clock = ~clock;

    assign ZeroE = (a == b);
    assign LtE   = ($signed(a) < $signed(b));
    assign LtuE  = (a < b);

    cu_rv32i #(.ALUC_W(4), .BRANCH_FULL(1'b1)) dut (
        .clock(clock), .reset(reset),
        .opD(opD), .funct3D(funct3D), .funct7b5D(funct7b5D),
        .ImmSrcD(ImmSrcD), .IllegalD(IllegalD),
        .StallE(StallE), .FlushE(FlushE), .FlushM(FlushM),
        .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE),
        .PCSrcE(PCSrcE), .PCTgtSrcE(PCTgtSrcE),
        .ALUControlE(ALUControlE), .ALUSrcAE(ALUSrcAE),
        .ALUSrcBE(ALUSrcBE), .ResultSrcEb0(ResultSrcEb0),
        .MemWriteM(MemWriteM), .MemSizeM(MemSizeM),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcW(ResultSrcW)
    );

    typedef struct packed {
        bit       rw;
        bit [1:0] rs;
        bit       mw;
        bit       jump;
        bit       br;
        bit [2:0] f3;
        bit [3:0] alu;
        bit       sa;
        bit       sb;
        bit       jalr;
    } ctl_t;

    ctl_t me, mm, mw;
    int   ntot = 0, npass = 0, nfail = 0;

    function automatic bit known(input bit [6:0] op);
        return op inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR,
                          OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    endfunction

    function automatic bit illegal(input bit [6:0] op, input bit [2:0] f3);
        if (op == 7'h00) return 1'b0;
        if (!known(op)) return 1'b1;
        return (op == OP_BR) && (f3 == 3'd2 || f3 == 3'd3);
    endfunction

    // Instruction mnemonic to ALU operation
    function automatic bit [3:0] arith(input bit [2:0] f3, input bit f7, input bit isr);
        case (f3)
            3'd0: return (isr && f7) ? A_SUB : A_ADD;
            3'd1: return A_SLL;
            3'd2: return A_SLT;
            3'd3: return A_SLTU;
            3'd4: return A_XOR;
            3'd5: return f7 ? A_SRA : A_SRL;
            3'd6: return A_OR;
            default: return A_AND;
        endcase
    endfunction

    function automatic ctl_t dec(input bit [6:0] op, input bit [2:0] f3, input bit f7);
        ctl_t c;
        c = '0;
        c.f3 = f3;
        if (op == OP_R) begin
            c.rw = 1; c.alu = arith(f3, f7, 1'b1);
        end else if (op == OP_I) begin
            c.rw = 1; c.sb = 1; c.alu = arith(f3, f7, 1'b0);
        end else if (op == OP_LD) begin
            c.rw = 1; c.rs = 2'd1; c.sb = 1; c.alu = A_ADD;
        end else if (op == OP_ST) begin
            c.mw = 1; c.sb = 1; c.alu = A_ADD;
        end else if (op == OP_BR) begin
            c.br = !illegal(op, f3); c.alu = A_SUB;
        end else if (op == OP_JAL) begin
            c.rw = 1; c.jump = 1; c.rs = 2'd2;
        end else if (op == OP_JALR) begin
            c.rw = 1; c.jump = 1; c.jalr = 1; c.rs = 2'd2; c.sb = 1; c.alu = A_ADD;
        end else if (op == OP_LUI) begin
            c.rw = 1; c.sb = 1; c.alu = A_PASSB;
        end else if (op == OP_AUIPC) begin
            c.rw = 1; c.sa = 1; c.sb = 1; c.alu = A_ADD;
        end
        return c;
    endfunction

    function automatic int imm_of(input bit [6:0] op);
        case (op)
            OP_I, OP_LD, OP_JALR: return 0;
            OP_ST:                return 1;
            OP_BR:                return 2;
            OP_JAL:               return 3;
            OP_LUI, OP_AUIPC:     return 4;
            default:              return -1;
        endcase
    endfunction

    // Branch outcome from the operands themselves, not from flag encoding
    function automatic bit taken(input bit [2:0] f3, input bit [31:0] x, input bit [31:0] y);
        case (f3)
            3'd0: return x == y;
            3'd1: return x != y;
            3'd4: return $signed(x) < $signed(y);
            3'd5: return $signed(x) >= $signed(y);
            3'd6: return x < y;
            3'd7: return x >= y;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int im;
        im = imm_of(opD);
        if (im >= 0) chk("ImmSrcD", 32'(ImmSrcD), 32'(im));
        chk("IllegalD", 32'(IllegalD), 32'(illegal(opD, funct3D)));
        chk("PCSrcE", 32'(PCSrcE), 32'(me.jump || (me.br && taken(me.f3, a, b))));
        chk("PCTgtSrcE", 32'(PCTgtSrcE), 32'(me.jalr));
        chk("ALUControlE", 32'(ALUControlE), 32'(me.alu));
        chk("ALUSrcAE", 32'(ALUSrcAE), 32'(me.sa));
        chk("ALUSrcBE", 32'(ALUSrcBE), 32'(me.sb));
        chk("ResultSrcEb0", 32'(ResultSrcEb0), 32'(me.rs[0]));
        chk("MemWriteM", 32'(MemWriteM), 32'(mm.mw));
        chk("MemSizeM", 32'(MemSizeM), 32'(mm.f3));
        chk("RegWriteM", 32'(RegWriteM), 32'(mm.rw));
        chk("RegWriteW", 32'(RegWriteW), 32'(mw.rw));
        chk("ResultSrcW", 32'(ResultSrcW), 32'(mw.rs));
    endtask

    task automatic cycle();
        ctl_t ne, nm, nw;
        #1;
        check_all();
        @(posedge clock);
        nw = reset ? '0 : mm;
        nm = (reset || FlushM || StallE) ? '0 : me;
        if (reset || FlushE) ne = '0;
        else if (StallE)     ne = me;
        else                 ne = dec(opD, funct3D, funct7b5D);
        me = ne;
        mm = nm;
        mw = nw;
        #1;
    endtask

    task automatic set(input bit [6:0] op, input bit [2:0] f3, input bit f7);
        opD = op;
        funct3D = f3;
        funct7b5D = f7;
    endtask

    initial begin
        bit [6:0] ops [11];
        ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR,
                OP_LUI, OP_AUIPC, 7'h00, 7'h7F};
        me = '0; mm = '0; mw = '0;
        reset = 1; StallE = 0; FlushE = 0; FlushM = 0;
        a = 0; b = 0;
        set(OP_R, 3'd0, 1'b1);
        cycle();
        cycle();
        chk("rst_ALUControlE", 32'(ALUControlE), 0);
        chk("rst_RegWriteW", 32'(RegWriteW), 0);
        chk("rst_MemWriteM", 32'(MemWriteM), 0);
        chk("rst_PCSrcE", 32'(PCSrcE), 0);
        reset = 0;

        set(OP_R, 3'd0, 1'b1);
        cycle();
        chk("sub_ALUControlE", 32'(ALUControlE), 1);
        set(7'h00, 3'd0, 1'b0);
        cycle();
        cycle();
        chk("sub_RegWriteW", 32'(RegWriteW), 1);

        set(OP_BR, 3'b100, 1'b0);
        a = 32'hFFFF_FFFB; b = 32'd3;
        cycle();
        chk("blt_PCSrcE", 32'(PCSrcE), 1);
        set(OP_BR, 3'b111, 1'b0);
        cycle();
        a = 32'd1; b = 32'd2;
        #1;
        chk("bgeu_PCSrcE", 32'(PCSrcE), 0);
        set(OP_BR, 3'b010, 1'b0);
        #1;
        chk("br010_IllegalD", 32'(IllegalD), 1);
        cycle();
        a = 32'd5; b = 32'd5;
        #1;
        chk("br010_PCSrcE", 32'(PCSrcE), 0);

        set(OP_JALR, 3'd0, 1'b0);
        cycle();
        chk("jalr_PCSrcE", 32'(PCSrcE), 1);
        chk("jalr_PCTgtSrcE", 32'(PCTgtSrcE), 1);
        set(7'h00, 3'd0, 1'b0);
        cycle();
        cycle();
        chk("jalr_ResultSrcW", 32'(ResultSrcW), 2);

        set(OP_LD, 3'b010, 1'b0);
        cycle();
        set(OP_R, 3'd0, 1'b1);
        StallE = 1;
        cycle();
        chk("stall_ResultSrcEb0", 32'(ResultSrcEb0), 1);
        chk("stall_ALUControlE", 32'(ALUControlE), 0);
        chk("stall_RegWriteM", 32'(RegWriteM), 0);
        StallE = 0;
        cycle();
        chk("lw_RegWriteM", 32'(RegWriteM), 1);
        chk("lw_MemSizeM", 32'(MemSizeM), 2);
        chk("after_ALUControlE", 32'(ALUControlE), 1);

        set(OP_ST, 3'b001, 1'b0);
        cycle();
        set(7'h00, 3'd0, 1'b0);
        cycle();
        chk("sh_MemWriteM", 32'(MemWriteM), 1);
        set(OP_ST, 3'b000, 1'b0);
        cycle();
        FlushM = 1;
        set(7'h00, 3'd0, 1'b0);
        cycle();
        chk("flushm_MemWriteM", 32'(MemWriteM), 0);
        FlushM = 0;

        set(OP_LD, 3'b000, 1'b0);
        cycle();
        FlushE = 1; StallE = 1;
        cycle();
        chk("flushstall_ResultSrcEb0", 32'(ResultSrcEb0), 0);
        FlushE = 0; StallE = 0;

        set(OP_LUI, 3'd0, 1'b0);
        cycle();
        chk("lui_ALUControlE", 32'(ALUControlE), 32'hA);
        set(OP_R, 3'd0, 1'b0);
        cycle();
        reset = 1;
        cycle();
        chk("midrst_RegWriteM", 32'(RegWriteM), 0);
        chk("midrst_RegWriteW", 32'(RegWriteW), 0);
        reset = 0;

        repeat (600) begin
            int k;
            k = $urandom_range(0, 10);
            set(ops[k], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            if (k == 10) opD = 7'($urandom);
            StallE = ($urandom_range(0, 7) == 0);
            FlushE = ($urandom_range(0, 9) == 0);
            FlushM = ($urandom_range(0, 9) == 0);
            reset  = ($urandom_range(0, 39) == 0);
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = $urandom_range(0, 15);
                default: b = $urandom;
            endcase
            cycle();
        end
        reset = 0;
        StallE = 0; FlushE = 0; FlushM = 0;
        cycle();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
